// File: rtl/dd_base_pkg.sv
// Converter-side constants shared with the DoubleDabble instance (N=32 -> 10 BCD digits).
package doubleDabblePkg;
  localparam int m_ddN           = 32;
  localparam int m_ddVectorWidth = 40;
endpackage

// File: rtl/dd_conv_scheduler_pkg.sv
// Types and constants for the shared DoubleDabble scheduler.
package ddSchedPkg;
  localparam int BCDW = doubleDabblePkg::m_ddVectorWidth;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} sched_state_t;

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/dd_conv_scheduler_arb.sv
// Combinational round-robin arbiter: first valid request at or after ptr, with wrap.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);
  function automatic logic [IDW-1:0] wrap(input int s);
    return IDW'((s >= NREQ) ? s - NREQ : s);
  endfunction

  // Walk offsets from the far end so the closest valid request is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[wrap(int'(ptr) + k)]) begin
        grant                        = '0;
        grant[wrap(int'(ptr) + k)]   = 1'b1;
        grant_idx                    = wrap(int'(ptr) + k);
        any                          = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dd_conv_scheduler.sv
// Shares one DoubleDabble converter among NREQ requesters with round-robin grant and a watchdog.
module dd_conv_scheduler
  import ddSchedPkg::*;
#(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4*N+8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         ReqValid,
  input  logic [NREQ-1:0][N-1:0]  ReqData,
  output logic [NREQ-1:0]         ReqReady,
  output logic                    RespValid,
  input  logic                    RespReady,
  output logic [$clog2(NREQ)-1:0] RespId,
  output logic [BCDW-1:0]         RespBCD,
  output logic                    RespErr,
  output logic                    ConvStart,
  output logic [N-1:0]            ConvV,
  input  logic                    ConvReady,
  input  logic [BCDW-1:0]         ConvBCD
);
  localparam int IDW = $clog2(NREQ);
  localparam int WDW = wd_width(TIMEOUT);

  sched_state_t    state;
  logic [IDW-1:0]  rr_ptr, id_q, grant_idx;
  logic [N-1:0]    op_q;
  logic [BCDW-1:0] bcd_q;
  logic            err_q, seen_busy, any;
  logic [WDW-1:0]  wd_cnt;
  logic [NREQ-1:0] grant;
  logic            wd_hit;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(ReqValid), .ptr(rr_ptr), .grant(grant), .grant_idx(grant_idx), .any(any)
  );

  assign ReqReady  = (state == S_IDLE) ? grant : '0;
  assign ConvStart = (state == S_ISSUE) && ConvReady;
  assign ConvV     = op_q;
  assign RespValid = (state == S_RESP);
  assign RespId    = id_q;
  assign RespBCD   = bcd_q;
  assign RespErr   = err_q;
  // >= so a start accepted on the last watchdog cycle still times out one cycle later.
  assign wd_hit    = (wd_cnt >= WDW'(TIMEOUT-1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      op_q      <= '0;
      id_q      <= '0;
      bcd_q     <= '0;
      err_q     <= 1'b0;
      wd_cnt    <= '0;
      seen_busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (any) begin
          op_q      <= ReqData[grant_idx];
          id_q      <= grant_idx;
          rr_ptr    <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
          err_q     <= 1'b0;
          wd_cnt    <= '0;
          seen_busy <= 1'b0;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          wd_cnt <= wd_cnt + WDW'(1);
          if (ConvReady) begin
            state <= S_BUSY;
          end else if (wd_hit) begin
            bcd_q <= '0;
            err_q <= 1'b1;
            state <= S_RESP;
          end
        end
        S_BUSY: begin
          wd_cnt <= wd_cnt + WDW'(1);
          if (!ConvReady) seen_busy <= 1'b1;
          // Completion wins over a coincident watchdog expiry.
          if (seen_busy && ConvReady) begin
            bcd_q <= ConvBCD;
            err_q <= 1'b0;
            state <= S_RESP;
          end else if (wd_hit) begin
            bcd_q <= '0;
            err_q <= 1'b1;
            state <= S_RESP;
          end
        end
        S_RESP: if (RespReady) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/dd_conv_scheduler.md
# dd_conv_scheduler

Shares one DoubleDabble binary-to-BCD converter among `NREQ` independent requesters. Requests are granted round-robin. The block sequences the converter's Start/Ready handshake, guards each conversion with a watchdog, and returns each result tagged with the requester ID. It sits between the requesting datapaths and a single DoubleDabble instance, so only one converter is needed per design.

## Interface
- `N`, default 32: binary operand width; must match the converter's `N`.
- `NREQ`, default 4: number of requesters, 2..16.
- `TIMEOUT`, default 4*N+8: maximum cycles from `ConvStart` to completion before the conversion is abandoned.
- `Clock`, in, 1: single clock; all logic is on its rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `ReqValid`, in, `NREQ`: per-requester request strobe.
- `ReqData`, in, `NREQ` x `N`: per-requester operand.
- `ReqReady`, out, `NREQ`: one-hot grant; the request is accepted when `ReqValid[i] & ReqReady[i]`.
- `RespValid`, out, 1: a response is held on the outputs.
- `RespReady`, in, 1: downstream accepts the response.
- `RespId`, out, clog2(`NREQ`): index of the requester that issued this result.
- `RespBCD`, out, `doubleDabblePkg::m_ddVectorWidth`: BCD result.
- `RespErr`, out, 1: the conversion timed out; `RespBCD` is 0.
- `ConvStart`, out, 1: drives the converter's `Start`.
- `ConvV`, out, `N`: drives the converter's `V`.
- `ConvReady`, in, 1: the converter's `Ready`.
- `ConvBCD`, in, `m_ddVectorWidth`: the converter's `BCD`.

## Operation
- State machine states: `S_IDLE`, `S_ISSUE`, `S_BUSY`, `S_RESP`.
- **S_IDLE**
  - The arbiter picks the first `i` with `ReqValid[i]=1`, searching upward (with wrap) from pointer `rr_ptr`.
  - `ReqReady` is driven one-hot to that `i`; it is all-zero if no request is valid.
  - On the handshake: `ReqData[i]` goes into `op_q`, `i` goes into `id_q`, `rr_ptr` becomes `(i+1) mod NREQ`, and the state moves to `S_ISSUE`.
- **S_ISSUE**
  - `ConvStart=1` while `ConvReady=1`.
  - Exits to `S_BUSY` on the first cycle that `ConvReady=1` is sampled; `ConvStart` is therefore high for exactly one accepted cycle.
  - If `ConvReady=0` on entry, it waits with `ConvStart=0`.
- **S_BUSY**
  - `ConvStart=0`.
  - Flag `seen_busy` is set when `ConvReady=0` is sampled.
  - Completion is `seen_busy & ConvReady`. On completion, `ConvBCD` goes into `bcd_q`, `RespErr=0`, and the state moves to `S_RESP`.
- **Watchdog**
  - `wd_cnt` clears when entering `S_ISSUE` and increments in `S_ISSUE` and `S_BUSY`.
  - At `wd_cnt == TIMEOUT-1` without completion: `bcd_q=0`, `err_q=1`, go to `S_RESP`.
  - Completion and timeout in the same cycle: completion wins.
- **S_RESP**
  - `RespValid=1`; `RespId`, `RespBCD` and `RespErr` come from registers and are stable until accepted.
  - On `RespReady=1`, go to `S_IDLE`. A new grant can occur in the next cycle, not the same cycle.
- **Inputs outside `S_IDLE`**: `ReqValid` is ignored and all `ReqReady` bits are 0.
- **`ConvV`**: always `op_q`. It is registered, so it is stable for the whole conversion.

## Timing
- **Reset values**: `ReqReady=0`, `RespValid=0`, `RespId=0`, `RespBCD=0`, `RespErr=0`, `ConvStart=0`, `ConvV=0`, `rr_ptr=0`, `wd_cnt=0`, `seen_busy=0`, state `S_IDLE`.
- **Reset mid-operation**: the in-flight request and any pending response are dropped with no response. The converter is assumed to share the same `Reset`.
- **Output sources**
  - `ReqReady` is combinational from state, `rr_ptr` and `ReqValid`.
  - All other outputs are registered or decoded from state.
- **Latency**: request accepted at cycle 0. `ConvStart` is seen at cycle 1 if the converter is idle. `RespValid` asserts one cycle after the converter's `Ready` returns high.
- **Throughput**: at most one conversion in flight.
- **Fairness**: a continuously valid requester waits at most `NREQ-1` other conversions.

## Structure
- **Package `ddSchedPkg`** holds:
  - `sched_state_t` enum.
  - `localparam` `BCDW = doubleDabblePkg::m_ddVectorWidth`.
  - The `TIMEOUT` width function.
- **Sub-module `rr_arbiter #(NREQ)`**: combinational.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `grant`, `grant_idx`, `any`.
  - The pointer update stays in the parent.
- The watchdog counter width is clog2(`TIMEOUT`+1).

## Test plan
- **Single request**: requester 0 sends `V=255` → exactly one `ConvStart` pulse; response `RespId=0`, `RespBCD=...0255`, `RespErr=0`.
- **Round-robin**: all four requesters held valid with `V=1,2,3,4` → responses in order ID 0,1,2,3 with BCD 1,2,3,4; then ID 0 is granted again.
- **Backpressure**: `RespReady=0` for 20 cycles → `RespValid`/`RespBCD` stable, `ReqReady` stays 0; release → the next grant comes one cycle after acceptance.
- **Boundary values**: `V=0` → BCD 0. `V=32'hFFFFFFFF` → BCD 4294967295.
- **Timeout**: stubbed converter holds `ConvReady=0` forever → at cycle `TIMEOUT` the response has `RespErr=1`, `RespBCD=0`, and the correct `RespId`.
- **Reset mid-operation**: `Reset` asserted while in `S_BUSY` → next cycle all outputs are at reset values, and the following grant goes to requester 0.
